data_bus: RTL and testbench

//  Single-cycle RV32I datapath: PC, instruction ROM, 32x32 register file, immediate extender, ALU,

---
 rtl/data_bus.sv | 129 ++++++++++++
 tb/tb_data_bus.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_bus.sv
// data_bus: single-cycle RV32I datapath (PC, instruction ROM, register file,
// immediate extender, ALU, data RAM, result mux). It is steered every cycle by
// an external main/ALU decoder, and it returns the opcode, funct3 and
// funct7b5 fields of the current instruction to that decoder.
// Every instruction ROM word is initialised to a NOP (addi x0,x0,0).
module data_bus #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "program.hex"
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PCSrc,
  input  logic [1:0] ResultSrc1_0,
  input  logic       MemWrite,
  input  logic [2:0] ALUControl2_0,
  input  logic       ALUSrc,
  input  logic [1:0] ImmSrc1_0,
  input  logic       RegWrite,
  output logic [6:0] Instr6_0,
  output logic [2:0] Instr14_12,
  output logic       Instr30,
  output logic       Zero
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] imm_ext;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic [31:0] read_data;
  logic [31:0] result;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  logic [31:0] rf [32];

  logic [31:0] imem [IMEM_DEPTH] = '{default: 32'h0000_0013};

  logic [31:0] dmem [DMEM_DEPTH] = '{default: '0};

  // Fetch: the word index is truncated, so PCs beyond the ROM size wrap.
  assign instr      = imem[pc[IMEM_AW+1:2]];
  assign rs1        = instr[19:15];
  assign rs2        = instr[24:20];
  assign rd         = instr[11:7];
  assign Instr6_0   = instr[6:0];
  assign Instr14_12 = instr[14:12];
  assign Instr30    = instr[30];

  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_ext;
  assign pc_next   = PCSrc ? pc_target : pc_plus4;

  // PC register; a reset restarts execution at address 0
  always_ff @(posedge CLK) begin
    if (RST) pc <= '0;
    else     pc <= pc_next;
  end

  // Combinational register reads. x0 is forced to zero, and same-cycle writes are not bypassed.
  assign rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];

  // Register file write port; reset clears every register and blocks writes
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite && (rd != 5'd0)) begin
      rf[rd] <= result;
    end
  end

  // Immediate extender: each format is sign-extended from instr[31]
  always_comb begin
    imm_ext = '0;
    unique case (ImmSrc1_0)
      2'b00: imm_ext = {{20{instr[31]}}, instr[31:20]};
      2'b01: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      2'b10: imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      2'b11: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  end

  assign src_b = ALUSrc ? imm_ext : rd2;

  // ALU: wrap-around add/sub, logic ops, signed set-less-than; unused codes give 0
  always_comb begin
    alu_result = '0;
    case (ALUControl2_0)
      3'b000:  alu_result = rd1 + src_b;
      3'b001:  alu_result = rd1 - src_b;
      3'b010:  alu_result = rd1 & src_b;
      3'b011:  alu_result = rd1 | src_b;
      3'b101:  alu_result = {31'b0, ($signed(rd1) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);

  // Data RAM: combinational read. Byte-offset bits are ignored and high address bits are truncated.
  assign read_data = dmem[alu_result[DMEM_AW+1:2]];

  // Data RAM word write; contents survive reset, and stores are blocked while reset is held
  always_ff @(posedge CLK) begin
    if (!RST && MemWrite) dmem[alu_result[DMEM_AW+1:2]] <= rd2;
  end

  // Result mux selecting the register write-back value
  always_comb begin
    result = alu_result;
    case (ResultSrc1_0)
      2'b01:   result = read_data;
      2'b10:   result = pc_plus4;
      default: result = alu_result;
    endcase
  end

endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed program for data_bus. The bench acts as the controller.
// It fills the ROM with a short hand-assembled program, drives the decoder
// controls for each instruction, and checks the architectural state against
// hand-computed values.
module tb_data_bus;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_src;
  logic [1:0] result_src;
  logic       mem_write;
  logic [2:0] alu_control;
  logic       alu_src;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  int checks = 0;
  int errors = 0;

  data_bus dut (
    .CLK          (clk),
    .RST          (rst),
    .PCSrc        (pc_src),
    .ResultSrc1_0 (result_src),
    .MemWrite     (mem_write),
    .ALUControl2_0(alu_control),
    .ALUSrc       (alu_src),
    .ImmSrc1_0    (imm_src),
    .RegWrite     (reg_write),
    .Instr6_0     (op),
    .Instr14_12   (funct3),
    .Instr30      (funct7b5),
    .Zero         (zero)
  );

  always #5 clk = ~clk;

  // Word-indexed program image
  logic [31:0] prog [20] = '{
    32'h00500093,  //  0: addi x1,x0,5
    32'h00C003EF,  //  4: jal  x7,+12      -> 16
    32'h00102423,  //  8: sw   x1,8(x0)
    32'h0080036F,  // 12: jal  x6,+8       -> 20
    32'hFE000CE3,  // 16: beq  x0,x0,-8    -> 8
    32'h00802203,  // 20: lw   x4,8(x0)
    32'h00500113,  // 24: addi x2,x0,5
    32'h402081B3,  // 28: sub  x3,x1,x2
    32'hFFF00093,  // 32: addi x1,x0,-1
    32'h00100113,  // 36: addi x2,x0,1
    32'h0020A2B3,  // 40: slt  x5,x1,x2
    32'h001127B3,  // 44: slt  x15,x2,x1
    32'h8F000413,  // 48: addi x8,x0,-1808
    32'h0FF00493,  // 52: addi x9,x0,255
    32'h00947533,  // 56: and  x10,x8,x9
    32'h009465B3,  // 60: or   x11,x8,x9
    32'h00708013,  // 64: addi x0,x1,7
    32'h00000633,  // 68: add  x12,x0,x0
    32'h10902683,  // 72: lw   x13,265(x0)
    32'hFB5FF86F   // 76: jal  x16,-76     -> 0
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ctl(input logic pcs, input logic [1:0] rs, input logic mw,
                         input logic [2:0] ac, input logic as, input logic [1:0] is,
                         input logic rw);
    pc_src = pcs; result_src = rs; mem_write = mw; alu_control = ac;
    alu_src = as; imm_src = is; reg_write = rw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_i();           set_ctl(1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 2'b00, 1'b1); endtask
  task automatic ctl_r(input logic [2:0] ac); set_ctl(1'b0, 2'b00, 1'b0, ac, 1'b0, 2'b00, 1'b1); endtask
  task automatic ctl_s();           set_ctl(1'b0, 2'b00, 1'b1, 3'b000, 1'b1, 2'b01, 1'b0); endtask
  task automatic ctl_l();           set_ctl(1'b0, 2'b01, 1'b0, 3'b000, 1'b1, 2'b00, 1'b1); endtask
  task automatic ctl_b();           set_ctl(1'b1, 2'b00, 1'b0, 3'b001, 1'b0, 2'b10, 1'b0); endtask
  task automatic ctl_j();           set_ctl(1'b1, 2'b10, 1'b0, 3'b000, 1'b0, 2'b11, 1'b1); endtask

  task automatic check_regs_clear(input string tag);
    int nonzero = 0;
    for (int r = 1; r < 32; r++) if (dut.rf[r] !== 32'd0) nonzero++;
    check(tag, nonzero, 0);
  endtask

  initial begin
    // Reset with the default NOP ROM
    rst = 1'b1;
    set_ctl(1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 2'b00, 1'b1);
    tick();
    check("rst_pc", dut.pc, 32'd0);
    check_regs_clear("rst_regs");
    check("rst_op", {25'd0, op}, 32'h13);
    check("rst_funct3", {29'd0, funct3}, 32'd0);
    check("rst_f7b5", {31'd0, funct7b5}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) dut.imem[i] = prog[i];
    #1;

    ctl_i(); tick();                              // addi x1,x0,5
    check("addi_x1", dut.rf[1], 32'd5);
    check("addi_pc", dut.pc, 32'd4);

    ctl_j(); tick();                              // jal x7,+12
    check("jal_pc", dut.pc, 32'd16);
    check("jal_link", dut.rf[7], 32'd8);

    ctl_b();                                      // beq x0,x0,-8
    check("beq_zero", {31'd0, zero}, 32'd1);
    check("beq_op", {25'd0, op}, 32'h63);
    tick();
    check("beq_pc", dut.pc, 32'd8);

    ctl_s(); tick();                              // sw x1,8(x0)
    check("sw_mem", dut.dmem[2], 32'd5);
    check("sw_pc", dut.pc, 32'd12);

    ctl_j(); tick();                              // jal x6,+8
    check("jal2_pc", dut.pc, 32'd20);
    check("jal2_link", dut.rf[6], 32'd16);

    ctl_l(); tick();                              // lw x4,8(x0)
    check("lw_x4", dut.rf[4], 32'd5);

    ctl_i(); tick();                              // addi x2,x0,5

    ctl_r(3'b001);                                // sub x3,x1,x2
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_f7b5", {31'd0, funct7b5}, 32'd1);
    check("sub_op", {25'd0, op}, 32'h33);
    tick();
    check("sub_x3", dut.rf[3], 32'd0);

    ctl_i(); tick();                              // addi x1,x0,-1
    check("addi_neg", dut.rf[1], 32'hFFFF_FFFF);
    ctl_i(); tick();                              // addi x2,x0,1

    ctl_r(3'b101);                                // slt x5,x1,x2
    check("slt_zero", {31'd0, zero}, 32'd0);
    check("slt_funct3", {29'd0, funct3}, 32'd2);
    tick();
    check("slt_x5", dut.rf[5], 32'd1);

    ctl_r(3'b101);                                // slt x15,x2,x1
    check("slt_rev_zero", {31'd0, zero}, 32'd1);
    tick();
    check("slt_x15", dut.rf[15], 32'd0);

    ctl_i(); tick();                              // addi x8,x0,-1808
    check("addi_x8", dut.rf[8], 32'hFFFF_F8F0);
    ctl_i(); tick();                              // addi x9,x0,255

    ctl_r(3'b010); tick();                        // and x10,x8,x9
    check("and_x10", dut.rf[10], 32'h0000_00F0);
    ctl_r(3'b011); tick();                        // or x11,x8,x9
    check("or_x11", dut.rf[11], 32'hFFFF_F8FF);

    ctl_i(); tick();                              // addi x0,x1,7 (discarded)
    ctl_r(3'b000);                                // add x12,x0,x0
    check("x0_zero", {31'd0, zero}, 32'd1);
    tick();
    check("x0_read", dut.rf[12], 32'd0);

    ctl_l(); tick();                              // lw x13,265(x0): wraps to word 2
    check("lw_wrap", dut.rf[13], 32'd5);

    ctl_j(); tick();                              // jal x16,-76
    check("jal_back_pc", dut.pc, 32'd0);
    check("jal_back_link", dut.rf[16], 32'd80);

    // Mid-program reset while addi x1 is fetched, with the write enables forced high
    rst = 1'b1;
    set_ctl(1'b0, 2'b00, 1'b1, 3'b000, 1'b1, 2'b00, 1'b1);
    tick();
    check("rst2_pc", dut.pc, 32'd0);
    check_regs_clear("rst2_regs");
    check("rst2_dmem_kept", dut.dmem[2], 32'd5);
    check("rst2_no_store", dut.dmem[1], 32'd0);
    check("rst2_op", {25'd0, op}, 32'h13);
    rst = 1'b0;

    ctl_i(); tick();                              // addi x1,x0,5 again
    check("restart_x1", dut.rf[1], 32'd5);
    check("restart_pc", dut.pc, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
